csi_dphy_lane_seq: RTL and testbench

CSI_DPHY_LANE_SEQ -- requirements
Module: csi_dphy_lane_seq

---
 rtl/csi_dphy_lane_seq.sv | 199 +++++++++++++++++++
 tb/tb_csi_dphy_lane_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_dphy_lane_seq.sv
// CSI-2 D-PHY data-lane sequencer.
// Takes one lane from LP-11 through the HS entry sequence (LP-01, LP-00,
// HS-zero, sync byte), streams payload bytes, then runs HS-trail and
// LP-11 exit before returning to idle.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   tx_req            : start a burst (sampled only while idle)
//   in_data/valid/last: payload byte stream; in_ready accepts a byte
//   lp_dp, lp_dn      : LP line levels
//   hs_en, hs_data    : HS driver enable and byte to the serializer
//   busy              : sequencer not idle
//   tx_done           : one-cycle pulse on return to idle after exit
//   underrun          : one-cycle pulse when the payload stream starves
//
// Line outputs (lp_*, hs_en, hs_data) are registered from the current
// state, so they trail the state register by one cycle.  An accepted byte
// therefore appears on hs_data in the cycle after acceptance, together with
// the line levels of the slot it was accepted in, and every payload byte
// gets its own HS slot ahead of the trail fill.  in_ready, busy, tx_done
// and underrun are registered from the state transition.
module csi_dphy_lane_seq #(
  parameter int unsigned P_T_LPX        = 4,
  parameter int unsigned P_T_HS_PREPARE = 3,
  parameter int unsigned P_T_HS_ZERO    = 10,
  parameter int unsigned P_T_HS_TRAIL   = 5,
  parameter int unsigned P_T_HS_EXIT    = 6,
  parameter int unsigned P_CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       hs_en,
  output logic [7:0] hs_data,
  output logic       busy,
  output logic       tx_done,
  output logic       underrun
);

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam logic [P_CNT_W-1:0] LD_LPX   = P_CNT_W'(P_T_LPX - 1);
  localparam logic [P_CNT_W-1:0] LD_PREP  = P_CNT_W'(P_T_HS_PREPARE - 1);
  localparam logic [P_CNT_W-1:0] LD_ZERO  = P_CNT_W'(P_T_HS_ZERO - 1);
  localparam logic [P_CNT_W-1:0] LD_TRAIL = P_CNT_W'(P_T_HS_TRAIL - 1);
  localparam logic [P_CNT_W-1:0] LD_EXIT  = P_CNT_W'(P_T_HS_EXIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_PAYLOAD, ST_TRAIL, ST_EXIT
  } state_t;

  state_t             state, state_d;
  logic [P_CNT_W-1:0] cnt, cnt_d;
  logic [7:0]         last_byte, last_byte_d;
  logic [7:0]         fill;
  logic [1:0]         lp_d;
  logic               hs_en_d;
  logic [7:0]         hs_data_d;
  logic               in_ready_d, busy_d, tx_done_d, underrun_d;
  logic               cnt_zero;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_byte <= SYNC_BYTE;
      lp_dp     <= 1'b1;
      lp_dn     <= 1'b1;
      hs_en     <= 1'b0;
      hs_data   <= 8'h00;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      last_byte <= last_byte_d;
      lp_dp     <= lp_d[1];
      lp_dn     <= lp_d[0];
      hs_en     <= hs_en_d;
      hs_data   <= hs_data_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      tx_done   <= tx_done_d;
      underrun  <= underrun_d;
    end
  end

  // Next state, counter reload and per-state line levels.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    last_byte_d = last_byte;
    lp_d        = 2'b11;
    hs_en_d     = 1'b0;
    hs_data_d   = 8'h00;
    underrun_d  = 1'b0;
    cnt_zero    = (cnt == '0);
    // Trail drives the inverse of the last transmitted bit 7.
    fill        = last_byte[7] ? 8'h00 : 8'hFF;

    case (state)
      ST_IDLE: begin
        if (tx_req) begin
          state_d = ST_LPX;
          cnt_d   = LD_LPX;
        end
      end
      ST_LPX: begin
        lp_d = 2'b01;
        if (cnt_zero) begin
          state_d = ST_PREP;
          cnt_d   = LD_PREP;
        end else begin
          cnt_d = cnt - P_CNT_W'(1);
        end
      end
      ST_PREP: begin
        lp_d = 2'b00;
        if (cnt_zero) begin
          state_d = ST_ZERO;
          cnt_d   = LD_ZERO;
        end else begin
          cnt_d = cnt - P_CNT_W'(1);
        end
      end
      ST_ZERO: begin
        lp_d    = 2'b00;
        hs_en_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_SYNC;
        end else begin
          cnt_d = cnt - P_CNT_W'(1);
        end
      end
      ST_SYNC: begin
        lp_d        = 2'b00;
        hs_en_d     = 1'b1;
        hs_data_d   = SYNC_BYTE;
        last_byte_d = SYNC_BYTE;
        state_d     = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        lp_d    = 2'b00;
        hs_en_d = 1'b1;
        if (in_valid) begin
          hs_data_d   = in_data;
          last_byte_d = in_data;
          if (in_last) begin
            state_d = ST_TRAIL;
            cnt_d   = LD_TRAIL;
          end
        end else begin
          // Starved: the empty slot already carries trail fill.
          hs_data_d  = fill;
          underrun_d = 1'b1;
          state_d    = ST_TRAIL;
          cnt_d      = LD_TRAIL;
        end
      end
      ST_TRAIL: begin
        lp_d      = 2'b00;
        hs_en_d   = 1'b1;
        hs_data_d = fill;
        if (cnt_zero) begin
          state_d = ST_EXIT;
          cnt_d   = LD_EXIT;
        end else begin
          cnt_d = cnt - P_CNT_W'(1);
        end
      end
      ST_EXIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - P_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d == ST_PAYLOAD);
    busy_d     = (state_d != ST_IDLE);
    tx_done_d  = (state == ST_EXIT) && (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_csi_dphy_lane_seq.sv
// Bench for csi_dphy_lane_seq: default-timing instance plus a minimum-timing
// instance sharing stimulus; one is observed at a time through a mux.
// Expected behaviour is built per burst as a timeline of line slots derived
// from the durations, the byte list and the underrun position.
module tb_csi_dphy_lane_seq;

  localparam int A_LPX = 4, A_PREP = 3, A_ZERO = 10, A_TRAIL = 5, A_EXIT = 6;
  localparam int B_LPX = 1, B_PREP = 1, B_ZERO = 1, B_TRAIL = 2, B_EXIT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_req, in_valid, in_last;
  logic [7:0] in_data;

  logic       a_in_ready, a_lp_dp, a_lp_dn, a_hs_en, a_busy, a_tx_done, a_underrun;
  logic [7:0] a_hs_data;
  logic       b_in_ready, b_lp_dp, b_lp_dn, b_hs_en, b_busy, b_tx_done, b_underrun;
  logic [7:0] b_hs_data;

  csi_dphy_lane_seq u_dut_a (
    .clk(clk), .rst(rst), .tx_req(tx_req), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(a_in_ready),
    .lp_dp(a_lp_dp), .lp_dn(a_lp_dn), .hs_en(a_hs_en), .hs_data(a_hs_data),
    .busy(a_busy), .tx_done(a_tx_done), .underrun(a_underrun)
  );

  csi_dphy_lane_seq #(
    .P_T_LPX(B_LPX), .P_T_HS_PREPARE(B_PREP), .P_T_HS_ZERO(B_ZERO),
    .P_T_HS_TRAIL(B_TRAIL), .P_T_HS_EXIT(B_EXIT), .P_CNT_W(8)
  ) u_dut_b (
    .clk(clk), .rst(rst), .tx_req(tx_req), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(b_in_ready),
    .lp_dp(b_lp_dp), .lp_dn(b_lp_dn), .hs_en(b_hs_en), .hs_data(b_hs_data),
    .busy(b_busy), .tx_done(b_tx_done), .underrun(b_underrun)
  );

  logic       sel;
  logic [1:0] o_lp;
  logic       o_en, o_rdy, o_busy, o_done, o_und;
  logic [7:0] o_d;
  assign o_lp   = sel ? {b_lp_dp, b_lp_dn} : {a_lp_dp, a_lp_dn};
  assign o_en   = sel ? b_hs_en    : a_hs_en;
  assign o_d    = sel ? b_hs_data  : a_hs_data;
  assign o_rdy  = sel ? b_in_ready : a_in_ready;
  assign o_busy = sel ? b_busy     : a_busy;
  assign o_done = sel ? b_tx_done  : a_tx_done;
  assign o_und  = sel ? b_underrun : a_underrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] plan[$];
  int         plan_u;
  bit         hold_req;
  bit         done_pending;
  logic [1:0] p_lp;
  logic       p_en;
  logic [7:0] p_d;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive_random();
    in_valid = 1'($urandom_range(0, 1));
    in_last  = 1'($urandom_range(0, 1));
    in_data  = 8'($urandom);
  endtask

  task automatic reset_check(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      tx_req = 1'($urandom_range(0, 1));
      drive_random();
      @(negedge clk);
      check_eq("rst_lp", o_lp, 2'b11);
      check_eq("rst_hs_en", o_en, 0);
      check_eq("rst_hs_data", o_d, 0);
      check_eq("rst_in_ready", o_rdy, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_tx_done", o_done, 0);
      check_eq("rst_underrun", o_und, 0);
    end
    p_lp = 2'b11; p_en = 1'b0; p_d = 8'h00;
    done_pending = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      tx_req = 1'b0;
      drive_random();
      @(negedge clk);
      check_eq("idle_lp", o_lp, 2'b11);
      check_eq("idle_hs_en", o_en, 0);
      check_eq("idle_hs_data", o_d, 0);
      check_eq("idle_in_ready", o_rdy, 0);
      check_eq("idle_busy", o_busy, 0);
      check_eq("idle_tx_done", o_done, 32'(done_pending));
      check_eq("idle_underrun", o_und, 0);
      done_pending = 1'b0;
    end
    p_lp = 2'b11; p_en = 1'b0; p_d = 8'h00;
  endtask

  task automatic random_plan();
    int n;
    plan.delete();
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) plan.push_back(8'($urandom));
    plan_u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
  endtask

  // One burst: t=0 is the idle cycle presenting tx_req; runs to the last
  // exit cycle.  tx_done is left pending for the following cycle.
  task automatic run_burst(input int l, input int p, input int z, input int tt, input int x);
    logic [1:0] s_lp [0:63];
    logic       s_en [0:63];
    logic [7:0] s_d  [0:63];
    int n, acc, s, pay0, tr0, e, idx;
    logic [7:0] last, fill;
    n    = plan.size();
    acc  = (plan_u >= 0) ? plan_u : n;
    s    = l + p + z + 1;
    pay0 = s + 1;
    tr0  = pay0 + ((plan_u >= 0) ? plan_u + 1 : n);
    e    = tr0 + tt + x;
    last = (acc == 0) ? 8'hB8 : plan[acc-1];
    fill = last[7] ? 8'h00 : 8'hFF;
    for (int t = 0; t < e; t++) begin
      s_lp[t] = 2'b00; s_en[t] = 1'b1; s_d[t] = 8'h00;
      if (t == 0 || t >= tr0 + tt) begin s_lp[t] = 2'b11; s_en[t] = 1'b0; end
      else if (t <= l)             begin s_lp[t] = 2'b01; s_en[t] = 1'b0; end
      else if (t <= l + p)         s_en[t] = 1'b0;
      else if (t == s)             s_d[t] = 8'hB8;
      else if (t >= pay0 && t < pay0 + acc) s_d[t] = plan[t-pay0];
      else if (t >= pay0)          s_d[t] = fill;
    end
    for (int t = 0; t < e; t++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      tx_req = (t == 0) || hold_req || ($urandom_range(0, 3) == 0);
      if (t >= pay0 && t < tr0) begin
        idx = t - pay0;
        if (idx == plan_u) begin
          drive_random();
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = plan[idx];
          in_last  = (idx == n - 1);
        end
      end else begin
        drive_random();
      end
      @(negedge clk);
      check_eq("lp", o_lp, p_lp);
      check_eq("hs_en", o_en, p_en);
      check_eq("hs_data", o_d, p_d);
      check_eq("busy", o_busy, 32'(t != 0));
      check_eq("in_ready", o_rdy, 32'(t >= pay0 && t < tr0));
      check_eq("tx_done", o_done, 32'(t == 0 && done_pending));
      check_eq("underrun", o_und, 32'(plan_u >= 0 && t == tr0));
      if (t == 0) done_pending = 1'b0;
      p_lp = s_lp[t]; p_en = s_en[t]; p_d = s_d[t];
    end
    done_pending = 1'b1;
  endtask

  // Start a burst, then reset while the lane is in HS-zero.
  task automatic abort_in_zero(input int l, input int p);
    for (int t = 0; t <= l + p + 2; t++) begin
      @(posedge clk); #1;
      rst = (t == l + p + 2);
      tx_req = (t == 0);
      drive_random();
      @(negedge clk);
      if (t == 0) begin
        check_eq("abort_tx_done", o_done, 32'(done_pending));
        done_pending = 1'b0;
      end
      if (t == l + p + 2) begin
        check_eq("abort_busy_pre", o_busy, 1);
        check_eq("abort_hs_en_pre", o_en, 1);
      end
    end
    p_lp = 2'b11; p_en = 1'b0; p_d = 8'h00;
    done_pending = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; tx_req = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    hold_req = 1'b0; done_pending = 1'b0;
    p_lp = 2'b11; p_en = 1'b0; p_d = 8'h00;
    plan_u = -1;

    reset_check(2);

    plan = '{8'h11, 8'h22, 8'h33}; plan_u = -1;
    run_burst(A_LPX, A_PREP, A_ZERO, A_TRAIL, A_EXIT);
    hold_req = 1'b1;
    plan = '{8'h80}; plan_u = -1;
    run_burst(A_LPX, A_PREP, A_ZERO, A_TRAIL, A_EXIT);
    plan = '{8'h11, 8'h44}; plan_u = 1;
    run_burst(A_LPX, A_PREP, A_ZERO, A_TRAIL, A_EXIT);
    hold_req = 1'b0;
    plan = '{8'h90, 8'h12}; plan_u = 0;
    run_burst(A_LPX, A_PREP, A_ZERO, A_TRAIL, A_EXIT);
    idle_cycles(2);

    for (int i = 0; i < 20; i++) begin
      random_plan();
      hold_req = ($urandom_range(0, 3) == 0);
      run_burst(A_LPX, A_PREP, A_ZERO, A_TRAIL, A_EXIT);
      hold_req = 1'b0;
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(1);
    abort_in_zero(A_LPX, A_PREP);
    random_plan();
    run_burst(A_LPX, A_PREP, A_ZERO, A_TRAIL, A_EXIT);
    idle_cycles(2);

    sel = 1'b1;
    reset_check(2);
    plan = '{8'h5A, 8'hC3}; plan_u = -1;
    run_burst(B_LPX, B_PREP, B_ZERO, B_TRAIL, B_EXIT);
    for (int i = 0; i < 10; i++) begin
      random_plan();
      hold_req = ($urandom_range(0, 2) == 0);
      run_burst(B_LPX, B_PREP, B_ZERO, B_TRAIL, B_EXIT);
      hold_req = 1'b0;
      idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
